fifo_read_streamer: RTL

Read-side companion to the team's FIFO memory block. It pops words from the FIFO read port and accounts for the FIFO's 1-cycle registered dout latency. Words are presented downstream on a valid/ready stream with a 2-entry skid buffer, giving one word per cycle at full throughput. A hold-off state machine batches reads while the FIFO is almost empty, trading latency for burstiness.

---
 rtl/fifo_read_streamer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/fifo_read_streamer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_read_streamer
// Description : Read-side companion to the FIFO memory block. Pops words from
//               the FIFO read port, absorbs the FIFO's 1-cycle registered dout
//               latency, and presents words on a valid/ready stream through a
//               2-entry skid buffer (one word per cycle at full throughput).
//               A hold-off FSM (IDLE/HOLD/DRAIN) batches reads while the FIFO
//               is almost empty.
// Ports       : clk        - clock, all logic on rising edge
//               reset_n    - synchronous active-low reset
//               en         - 0 = issue no new FIFO reads
//               flush      - drain regardless of fifo_ale
//               fifo_empty - FIFO empty flag
//               fifo_ale   - FIFO almost-empty flag
//               fifo_dout  - FIFO read data, valid 1 cycle after a read
//               fifo_read  - FIFO read strobe (combinational)
//               m_valid / m_ready / m_data - downstream stream
//               state_o    - FSM state: 0 IDLE, 1 HOLD, 2 DRAIN
//               rd_count   - delivered-word counter
// Options     : FIFO_RD_STATS_EN - when defined, rd_count counts pops and
//               saturates at 0xFFFF; when undefined rd_count is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_streamer #(
    parameter int DATA_WIDTH  = 8,
    parameter int HOLD_CYCLES = 8,
    parameter int TIMER_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic                  fifo_ale,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_read,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            state_o,
    output logic [15:0]           rd_count
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_HOLD  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    // Last timer value spent in HOLD; only meaningful when HOLD is enabled.
    localparam logic [TIMER_W-1:0] c_HOLD_LAST = TIMER_W'(HOLD_CYCLES - 1);
    localparam bit                 c_HOLD_EN   = (HOLD_CYCLES != 0);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [TIMER_W-1:0]    r_timer;
    logic [TIMER_W-1:0]    w_timer_nxt;

    logic [1:0]            r_occ;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf0;      // buffer head, drives m_data
    logic [DATA_WIDTH-1:0] r_buf1;

    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_level;
    logic                  w_fifo_read;

    assign w_pop  = m_valid && m_ready;
    assign w_push = r_inflight;

    // Words already committed to the buffer once this cycle's pop is taken.
    // A new read is only safe when at most one slot is spoken for, so the
    // returning word always finds a free entry.
    assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        case (r_state)
            c_ST_IDLE: begin
                if (!fifo_empty) begin
                    if (flush || !fifo_ale || !c_HOLD_EN) begin
                        w_state_nxt = c_ST_DRAIN;
                    end else begin
                        w_state_nxt = c_ST_HOLD;
                        w_timer_nxt = '0;
                    end
                end
            end
            c_ST_HOLD: begin
                w_timer_nxt = r_timer + 1'b1;
                // Nothing left to batch: fall back rather than drain air.
                if (fifo_empty) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (!fifo_ale || flush || (r_timer == c_HOLD_LAST)) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (fifo_empty && !w_fifo_read) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_fifo_read = reset_n && en && (r_state == c_ST_DRAIN) &&
                      !fifo_empty && (w_level <= 3'd1);
    end

    assign fifo_read = w_fifo_read;
    assign state_o   = r_state;

    // ------------------------------------------------------------------
    // Read-latency tracker and 2-entry skid buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            r_inflight <= w_fifo_read;
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0 <= fifo_dout;
                    end else begin
                        r_buf1 <= fifo_dout;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind
                    // whatever remains after the head leaves.
                    if (r_occ == 2'd2) begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= fifo_dout;
                    end else begin
                        r_buf0 <= fifo_dout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign m_valid = (r_occ != 2'd0);
    assign m_data  = r_buf0;

    // ------------------------------------------------------------------
    // Delivered-word statistics
    // ------------------------------------------------------------------
`ifdef FIFO_RD_STATS_EN
    logic [15:0] r_rd_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_count <= '0;
        end else if (w_pop && (r_rd_count != 16'hFFFF)) begin
            r_rd_count <= r_rd_count + 16'd1;
        end
    end

    assign rd_count = r_rd_count;
`else
    assign rd_count = '0;
`endif

endmodule
`default_nettype wire
